// File: rtl/mant_align_if.sv
// Operand/result bus of the mantissa alignment pipeline.
// The producer/consumer side uses the master modport, the alignment block the slave modport.
interface mant_align_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  // Input side: operand pair and its handshake
  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  exp_a;
  logic [EXP_W-1:0]  exp_b;
  logic [MANT_W-1:0] mant_a;
  logic [MANT_W-1:0] mant_b;

  // Output side: aligned pair and its handshake
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W+2:0] mant_big;
  logic [MANT_W+2:0] mant_small;
  logic              swapped;

  modport master (
    output in_valid, exp_a, exp_b, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, exp_out, mant_big, mant_small, swapped
  );

  modport slave (
    input  in_valid, exp_a, exp_b, mant_a, mant_b, out_ready,
    output in_ready, out_valid, exp_out, mant_big, mant_small, swapped
  );
endinterface

// File: rtl/mant_align.sv
// Floating-point add/sub front end: orders two operands by exponent and
// right-aligns the smaller mantissa with guard/round/sticky bits.
// Stage 1 compares exponents and swaps; stage 2 performs the sticky shift.
// Both ends use valid/ready; one pair per cycle, two cycles of latency.
module mant_align #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  mant_align_if.slave  bus
);

  // Extended mantissa width: MANT_W bits plus guard, round and sticky.
  localparam int EXT_W = MANT_W + 3;

  // Stage 1 registers: ordered operands and exponent difference
  logic              r_s1_valid;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [MANT_W-1:0] r_s1_big;
  logic [MANT_W-1:0] r_s1_small;
  logic [EXP_W-1:0]  r_s1_d;
  logic              r_s1_swapped;

  // Stage 2 registers: drive the outputs directly
  logic              r_s2_valid;
  logic [EXP_W-1:0]  r_s2_exp;
  logic [EXT_W-1:0]  r_s2_big;
  logic [EXT_W-1:0]  r_s2_small;
  logic              r_s2_swapped;

  // Pipeline control
  logic              w_s2_load;
  logic              w_s1_move;
  logic              w_s1_load;
  logic              w_in_fire;

  // Stage 1 combinational compare/swap
  logic              w_b_bigger;
  logic [EXP_W-1:0]  w_exp_big;
  logic [EXP_W-1:0]  w_exp_small;
  logic [MANT_W-1:0] w_mant_big;
  logic [MANT_W-1:0] w_mant_small;

  // Stage 2 combinational alignment
  logic [EXT_W-1:0]  w_ext;
  logic [EXT_W-1:0]  w_shifted;
  logic [EXT_W-1:0]  w_lost_mask;
  logic              w_sticky;
  logic              w_saturate;
  logic [EXT_W-1:0]  w_aligned;

  // Stage 2 accepts when it is empty or its content leaves this cycle.
  // Stage 1 accepts when it is empty or its content moves into stage 2,
  // so in_ready never looks at in_valid and full-pipe streaming keeps
  // one pair per cycle when the consumer is ready.
  always_comb begin
    w_s2_load = !r_s2_valid || bus.out_ready;
    w_s1_move = r_s1_valid && w_s2_load;
    w_s1_load = !r_s1_valid || w_s1_move;
    w_in_fire = bus.in_valid && w_s1_load;
  end

  assign bus.in_ready = w_s1_load;

  // Exponent compare: B wins only when strictly larger, ties keep A big.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    w_b_bigger   = 1'b0;
    w_exp_big    = bus.exp_a;
    w_exp_small  = bus.exp_b;
    w_mant_big   = bus.mant_a;
    w_mant_small = bus.mant_b;
    if (bus.exp_b > bus.exp_a) begin
      w_b_bigger   = 1'b1;
      w_exp_big    = bus.exp_b;
      w_exp_small  = bus.exp_a;
      w_mant_big   = bus.mant_b;
      w_mant_small = bus.mant_a;
    end
  end

  // Stage 1 register: capture ordered operands and the unsigned difference
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: data registers are reset as well as valid flags, so the
      // outputs read as zero after reset instead of holding stale data.
      r_s1_valid   <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_big     <= '0;
      r_s1_small   <= '0;
      r_s1_d       <= '0;
      r_s1_swapped <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= bus.in_valid;
      if (w_in_fire) begin
        r_s1_exp     <= w_exp_big;
        r_s1_big     <= w_mant_big;
        r_s1_small   <= w_mant_small;
        r_s1_d       <= w_exp_big - w_exp_small;
        r_s1_swapped <= w_b_bigger;
      end
    end
  end

  // Sticky right shift of the smaller mantissa by the exponent difference.
  // Bits falling off the bottom are OR-ed into bit 0; shifts at or beyond
  // the extended width collapse the whole mantissa into the sticky bit.
  always_comb begin
    w_ext       = {r_s1_small, 3'b000};
    w_saturate  = (32'(r_s1_d) >= 32'(EXT_W));
    w_shifted   = '0;
    w_lost_mask = '0;
    w_sticky    = 1'b0;
    w_aligned   = '0;
    if (w_saturate) begin
      w_aligned = {{(EXT_W-1){1'b0}}, |r_s1_small};
    end else begin
      w_shifted   = w_ext >> r_s1_d;
      w_lost_mask = ~({EXT_W{1'b1}} << r_s1_d);
      w_sticky    = |(w_ext & w_lost_mask);
      w_aligned   = {w_shifted[EXT_W-1:1], w_shifted[0] | w_sticky};
    end
  end

  // Stage 2 register: holds the result stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_exp     <= '0;
      r_s2_big     <= '0;
      r_s2_small   <= '0;
      r_s2_swapped <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_exp     <= r_s1_exp;
        r_s2_big     <= {r_s1_big, 3'b000};
        r_s2_small   <= w_aligned;
        r_s2_swapped <= r_s1_swapped;
      end
    end
  end

  assign bus.out_valid  = r_s2_valid;
  assign bus.exp_out    = r_s2_exp;
  assign bus.mant_big   = r_s2_big;
  assign bus.mant_small = r_s2_small;
  assign bus.swapped    = r_s2_swapped;

endmodule
